// File: rtl/hdr_pkg.sv
// Shared widths and result type for the HDR merge accumulator.
// The derived widths guarantee the sums cannot overflow for up to 2^ACC_GUARD beats.
package hdr_pkg;

    localparam int W_WIDTH   = 8;
    localparam int V_WIDTH   = 16;
    localparam int N_EXP     = 3;
    localparam int ACC_GUARD = 4;

    localparam int PROD_W   = W_WIDTH + V_WIDTH + 1;
    localparam int WSUM_W   = W_WIDTH + ACC_GUARD;
    localparam int ACC_WV_W = PROD_W + ACC_GUARD;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic [WSUM_W-1:0]          wsum;
        logic signed [ACC_WV_W-1:0] wvsum;
        logic                       zero;
        logic                       err;
    } hdr_result_t;

    function automatic logic signed [ACC_WV_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_WV_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/hdr_mul_reg.sv
// Stage-1 registered unsigned-weight x signed-value multiplier, kept separate so
// the multiply-plus-register maps cleanly onto a single DSP slice.
module hdr_mul_reg
    import hdr_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [W_WIDTH-1:0]       weight,
    input  logic signed [V_WIDTH-1:0] value,
    output logic signed [PROD_W-1:0] prod
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    // Zero-extended weight keeps the product signed without losing weight bit 7.
    assign a_ext = {{(PROD_W-W_WIDTH){1'b0}}, weight};
    assign b_ext = {{(PROD_W-V_WIDTH){value[V_WIDTH-1]}}, value};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod <= '0;
        end else if (en) begin
            prod <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/hdr_weight_accum.sv
// Per-pixel accumulator producing sum(w) and sum(w*v) over one beat per exposure,
// with an error flag when the pixel's beat count differs from N_EXP.
module hdr_weight_accum
    import hdr_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [W_WIDTH-1:0]          s_weight,
    input  logic signed [V_WIDTH-1:0]   s_value,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WSUM_W-1:0]           m_wsum,
    output logic signed [ACC_WV_W-1:0]  m_wvsum,
    output logic                        m_zero,
    output logic                        m_err
);

    logic                       stall;
    logic                       accept;
    logic                       load;
    logic                       p1_valid;
    logic                       p1_last;
    logic [W_WIDTH-1:0]         p1_w;
    logic signed [PROD_W-1:0]   p1_prod;
    logic [WSUM_W-1:0]          acc_w;
    logic signed [ACC_WV_W-1:0] acc_wv;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W:0]             cnt_inc;
    logic [WSUM_W-1:0]          wsum_next;
    logic signed [ACC_WV_W-1:0] wvsum_next;
    hdr_result_t                res;

    // A held, unconsumed result freezes the whole pipeline.
    assign stall  = m_valid & ~m_ready;
    assign s_ready = ~stall;
    assign accept = s_valid & s_ready;
    assign load   = p1_valid & p1_last & ~stall;

    assign cnt_inc    = {1'b0, cnt} + 1'b1;
    assign wsum_next  = acc_w + WSUM_W'(p1_w);
    assign wvsum_next = acc_wv + sext_prod(p1_prod);

    hdr_mul_reg u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .weight  (s_weight),
        .value   (s_value),
        .prod    (p1_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            p1_w     <= '0;
        end else if (!stall) begin
            p1_valid <= accept;
            if (accept) begin
                p1_w    <= s_weight;
                p1_last <= s_last;
            end
        end
    end

    // The beat count saturates so that over-long pixels can never alias back to N_EXP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_w  <= '0;
            acc_wv <= '0;
            cnt    <= '0;
        end else if (p1_valid && !stall) begin
            if (p1_last) begin
                acc_w  <= '0;
                acc_wv <= '0;
                cnt    <= '0;
            end else begin
                acc_w  <= wsum_next;
                acc_wv <= wvsum_next;
                cnt    <= (cnt == '1) ? cnt : cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            res     <= '0;
        end else if (load) begin
            m_valid    <= 1'b1;
            res.wsum   <= wsum_next;
            res.wvsum  <= wvsum_next;
            res.zero   <= (wsum_next == '0);
            res.err    <= (cnt_inc != (CNT_W+1)'(N_EXP));
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign m_wsum  = res.wsum;
    assign m_wvsum = res.wvsum;
    assign m_zero  = res.zero;
    assign m_err   = res.err;

endmodule

// File: tb/tb_hdr_weight_accum.sv
// Directed bench for hdr_weight_accum: table-driven pixels plus hand-written
// latency, backpressure, overrun and mid-pixel reset sequences.
module tb_hdr_weight_accum;
    import hdr_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       s_valid = 1'b0;
    logic                       s_ready;
    logic [W_WIDTH-1:0]         s_weight = '0;
    logic signed [V_WIDTH-1:0]  s_value = '0;
    logic                       s_last = 1'b0;
    logic                       m_valid;
    logic                       m_ready = 1'b1;
    logic [WSUM_W-1:0]          m_wsum;
    logic signed [ACC_WV_W-1:0] m_wvsum;
    logic                       m_zero;
    logic                       m_err;

    int checks = 0;
    int errors = 0;
    hdr_result_t got_q[$];

    typedef struct {
        logic [W_WIDTH-1:0]        w;
        logic signed [V_WIDTH-1:0] v;
        logic                      last;
        hdr_result_t               exp;
    } vec_t;

    vec_t vec[12];

    hdr_weight_accum dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_weight (s_weight),
        .s_value  (s_value),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_wsum   (m_wsum),
        .m_wvsum  (m_wvsum),
        .m_zero   (m_zero),
        .m_err    (m_err)
    );

    always #5 clk = ~clk;

    // Every result the downstream actually consumes, in order.
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready)
            got_q.push_back({m_wsum, m_wvsum, m_zero, m_err});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string name, input hdr_result_t exp);
        hdr_result_t r;
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no result expected wsum %0d", name, exp.wsum);
        end else begin
            r = got_q.pop_front();
            checkOutput({name, ".wsum"},  r.wsum,  exp.wsum);
            checkOutput({name, ".wvsum"}, r.wvsum, exp.wvsum);
            checkOutput({name, ".zero"},  r.zero,  exp.zero);
            checkOutput({name, ".err"},   r.err,   exp.err);
        end
    endtask

    task automatic checkEmpty(input string name);
        checkOutput(name, 64'(got_q.size()), 64'd0);
        got_q.delete();
    endtask

    task automatic applyStimulus(input logic [W_WIDTH-1:0] w, input logic signed [V_WIDTH-1:0] v,
                                 input logic last);
        bit done = 0;
        s_valid  = 1'b1;
        s_weight = w;
        s_value  = v;
        s_last   = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept: got s_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic waitValid(input string name, input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (m_valid) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got m_valid 0 expected 1 within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic setVec(input int i, input logic [W_WIDTH-1:0] w, input logic signed [V_WIDTH-1:0] v,
                          input logic last, input int ws, input int wv, input logic z, input logic e);
        vec[i].w         = w;
        vec[i].v         = v;
        vec[i].last      = last;
        vec[i].exp.wsum  = WSUM_W'(ws);
        vec[i].exp.wvsum = ACC_WV_W'(wv);
        vec[i].exp.zero  = z;
        vec[i].exp.err   = e;
    endtask

    initial begin
        hdr_result_t e;

        setVec(0,  8'd10,  16'sd100,    1'b0, 0,   0,        1'b0, 1'b0);
        setVec(1,  8'd20,  -16'sd50,    1'b0, 0,   0,        1'b0, 1'b0);
        setVec(2,  8'd127, 16'sd2,      1'b1, 157, 254,      1'b0, 1'b0);
        setVec(3,  8'd0,   16'sd1234,   1'b0, 0,   0,        1'b0, 1'b0);
        setVec(4,  8'd0,   -16'sd999,   1'b0, 0,   0,        1'b0, 1'b0);
        setVec(5,  8'd0,   16'sd77,     1'b1, 0,   0,        1'b1, 1'b0);
        setVec(6,  8'd5,   -16'sd3,     1'b0, 0,   0,        1'b0, 1'b0);
        setVec(7,  8'd6,   16'sd4,      1'b1, 11,  9,        1'b0, 1'b1);
        setVec(8,  8'd1,   -16'sd7,     1'b0, 0,   0,        1'b0, 1'b0);
        setVec(9,  8'd2,   16'sd3,      1'b0, 0,   0,        1'b0, 1'b0);
        setVec(10, 8'd3,   -16'sd1,     1'b1, 6,   -4,       1'b0, 1'b0);
        setVec(11, 8'd127, -16'sd32768, 1'b1, 127, -4161536, 1'b0, 1'b1);

        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset.m_valid", m_valid, 0);
        checkOutput("reset.m_wsum",  m_wsum,  0);
        checkOutput("reset.m_wvsum", m_wvsum, 0);
        checkOutput("reset.m_zero",  m_zero,  0);
        checkOutput("reset.m_err",   m_err,   0);
        checkOutput("reset.s_ready", s_ready, 1);

        // Two-cycle latency and a single-cycle valid pulse.
        applyStimulus(8'd10, 16'sd100, 1'b0);
        applyStimulus(8'd20, -16'sd50, 1'b0);
        applyStimulus(8'd127, 16'sd2, 1'b1);
        s_valid = 1'b0;
        checkOutput("lat.valid_t1", m_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("lat.valid_t2", m_valid, 1);
        checkOutput("lat.wsum",  m_wsum,  157);
        checkOutput("lat.wvsum", m_wvsum, 254);
        @(posedge clk);
        #1;
        checkOutput("lat.pulse_end", m_valid, 0);
        got_q.delete();

        // Back-to-back table pixels.
        for (int i = 0; i < 12; i++)
            applyStimulus(vec[i].w, vec[i].v, vec[i].last);
        s_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++)
            if (vec[i].last) checkResult($sformatf("table[%0d]", i), vec[i].exp);
        checkEmpty("table.extra_results");

        // Backpressure: A held while B waits, then both delivered once.
        m_ready = 1'b0;
        fork
            begin
                applyStimulus(8'd100, 16'sd300, 1'b0);
                applyStimulus(8'd50, -16'sd600, 1'b0);
                applyStimulus(8'd1, 16'sd1, 1'b1);
                applyStimulus(8'd3, 16'sd1000, 1'b0);
                applyStimulus(8'd4, -16'sd250, 1'b0);
                applyStimulus(8'd5, 16'sd7, 1'b1);
                s_valid = 1'b0;
            end
            begin
                waitValid("bp.A_valid", 50);
                checkOutput("bp.s_ready_low", s_ready, 0);
                checkOutput("bp.A.wsum", m_wsum, 151);
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    checkOutput("bp.hold.valid", m_valid, 1);
                    checkOutput("bp.hold.wsum",  m_wsum,  151);
                    checkOutput("bp.hold.wvsum", m_wvsum, 1);
                end
                m_ready = 1'b1;
                @(posedge clk);
                #1;
                m_ready = 1'b0;
                checkOutput("bp.A_consumed", m_valid, 0);
                waitValid("bp.B_valid", 50);
                checkOutput("bp.B.wsum",  m_wsum,  12);
                checkOutput("bp.B.wvsum", m_wvsum, 2035);
                m_ready = 1'b1;
                @(posedge clk);
                #1;
            end
        join
        e = {12'd151, 29'sd1, 1'b0, 1'b0};
        checkResult("bp.A", e);
        e = {12'd12, 29'sd2035, 1'b0, 1'b0};
        checkResult("bp.B", e);
        checkEmpty("bp.extra_results");

        // Overrun: 21 beats must flag an error, never wrap to a good count.
        for (int i = 0; i < 20; i++)
            applyStimulus(8'd1, 16'sd1, 1'b0);
        applyStimulus(8'd1, 16'sd1, 1'b1);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        e = {12'd21, 29'sd21, 1'b0, 1'b1};
        checkResult("overrun", e);
        checkEmpty("overrun.extra_results");

        // Reset while a result is held and a partial pixel sits in the pipeline.
        m_ready = 1'b0;
        applyStimulus(8'd50, 16'sd50, 1'b1);
        applyStimulus(8'd9, 16'sd9, 1'b0);
        s_valid = 1'b1;
        checkOutput("rst.pre_valid", m_valid, 1);
        checkOutput("rst.pre_wsum",  m_wsum,  50);
        #3 reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        checkOutput("rst.m_valid", m_valid, 0);
        checkOutput("rst.m_wsum",  m_wsum,  0);
        checkOutput("rst.m_wvsum", m_wvsum, 0);
        checkOutput("rst.m_zero",  m_zero,  0);
        checkOutput("rst.m_err",   m_err,   0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst.s_ready", s_ready, 1);
        m_ready = 1'b1;
        got_q.delete();
        applyStimulus(8'd1, 16'sd1, 1'b0);
        applyStimulus(8'd1, 16'sd1, 1'b0);
        applyStimulus(8'd1, 16'sd1, 1'b1);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        e = {12'd3, 29'sd3, 1'b0, 1'b0};
        checkResult("post_reset", e);
        checkEmpty("post_reset.extra_results");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
